// File: rtl/trig_busy_ctrl.sv
// trig_busy_ctrl: trigger accept / busy generation with deadtime, outstanding-event
// throttle (hysteresis) and saturating status counters, all on distDivClk.
// Ports:
//   in : distDivClk, distDivClkRstL (sync, active low), enable, trigger, spill,
//        readoutDone, clearCounters
//   out: busy, triggerAccept, outstanding[OUT_W], trigAcceptCnt[32],
//        trigVetoCnt[32], spillCnt[16], underflowErr
module trig_busy_ctrl #(
  parameter int OUT_W    = 4,
  parameter int HIGH_WM  = 6,
  parameter int LOW_WM   = 3,
  parameter int DEADTIME = 4
) (
  input  logic             distDivClk,
  input  logic             distDivClkRstL,
  input  logic             enable,
  input  logic             trigger,
  input  logic             spill,
  input  logic             readoutDone,
  input  logic             clearCounters,
  output logic             busy,
  output logic             triggerAccept,
  output logic [OUT_W-1:0] outstanding,
  output logic [31:0]      trigAcceptCnt,
  output logic [31:0]      trigVetoCnt,
  output logic [15:0]      spillCnt,
  output logic             underflowErr
);

  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [OUT_W-1:0] HIGH = OUT_W'(HIGH_WM);
  localparam logic [OUT_W-1:0] LOW  = OUT_W'(LOW_WM);
  localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEADTIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DEAD,
    THROTTLED
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DT_W-1:0] dcnt;
  logic [DT_W-1:0] dcnt_nxt;
  logic            trig_q;
  logic            spill_q;
  logic            trig_edge;
  logic            spill_rise;
  logic            accept;
  logic            veto;
  logic            out_high;
  logic            out_low;
  logic            out_zero;

  assign trig_edge  = trigger & ~trig_q;
  assign spill_rise = spill & ~spill_q;
  assign accept     = enable & trig_edge & (state == ARMED);
  assign veto       = enable & trig_edge & (state != ARMED);
  assign out_high   = outstanding >= HIGH;
  assign out_low    = outstanding <= LOW;
  assign out_zero   = outstanding == '0;

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (spill) state_nxt = ARMED;
        end
        ARMED: begin
          if (trig_edge) begin
            state_nxt = DEAD;
            dcnt_nxt  = DT_LOAD;
          end else if (!spill) begin
            state_nxt = IDLE;
          end
        end
        DEAD: begin
          if (dcnt != '0) dcnt_nxt = dcnt - DT_W'(1);
          else if (out_high) state_nxt = THROTTLED;
          else if (spill) state_nxt = ARMED;
          else state_nxt = IDLE;
        end
        THROTTLED: begin
          if (out_low) state_nxt = spill ? ARMED : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // busy is registered from the next state so it moves with the state register
  always_ff @(posedge distDivClk) begin
    if (!distDivClkRstL) begin
      state         <= IDLE;
      dcnt          <= '0;
      busy          <= 1'b1;
      triggerAccept <= 1'b0;
      trig_q        <= 1'b0;
      spill_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      dcnt          <= dcnt_nxt;
      busy          <= (state_nxt != ARMED);
      triggerAccept <= accept;
      trig_q        <= trigger;
      spill_q       <= spill;
    end
  end

  // an accept and a readout in the same cycle cancel; the drained event
  // is the one just accepted, so no underflow is flagged then
  always_ff @(posedge distDivClk) begin
    if (!distDivClkRstL) begin
      outstanding  <= '0;
      underflowErr <= 1'b0;
    end else begin
      if (accept && !readoutDone)
        outstanding <= outstanding + OUT_W'(1);
      else if (readoutDone && !accept && !out_zero)
        outstanding <= outstanding - OUT_W'(1);
      if (clearCounters)
        underflowErr <= 1'b0;
      else if (readoutDone && !accept && out_zero)
        underflowErr <= 1'b1;
    end
  end

  always_ff @(posedge distDivClk) begin
    if (!distDivClkRstL) begin
      trigAcceptCnt <= '0;
      trigVetoCnt   <= '0;
      spillCnt      <= '0;
    end else if (clearCounters) begin
      trigAcceptCnt <= '0;
      trigVetoCnt   <= '0;
      spillCnt      <= '0;
    end else begin
      if (accept && trigAcceptCnt != '1)
        trigAcceptCnt <= trigAcceptCnt + 32'd1;
      if (veto && trigVetoCnt != '1)
        trigVetoCnt <= trigVetoCnt + 32'd1;
      if (enable && spill_rise && spillCnt != '1)
        spillCnt <= spillCnt + 16'd1;
    end
  end

endmodule
